snake_item_placer: RTL
======================

# snake_item_placer

Item-placement sequencer for the snake game. On a start pulse from the game FSM it draws a pseudo-random playfield cell and scans the snake body memory through a read port. It rejects any cell occupied by the head or a body segment, then returns a free cell with a done pulse. It owns the body-RAM read port while busy and drives the game FSM's "item made" handshake.

## Interface
- XSIZE, 48, playfield width; legal cells x = 1..XSIZE; 32 ≤ XSIZE ≤ 64
- YSIZE, 64, playfield height; legal cells y = 1..YSIZE; 32 ≤ YSIZE ≤ 64
- MAX_SIZE, 3072, body-RAM depth, equal to XSIZE*YSIZE
- ADDR_W, 12, body-RAM address / size width
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- i_Clk  in  1  clock; single clock domain
- i_Rst  in  1  reset, synchronous, active-high
- i_Start  in  1  placement request; sampled only in IDLE
- i_Head_x, i_Head_y  in  7 each  current head cell
- i_Size  in  ADDR_W  number of valid body entries (indices 0..i_Size-1); values above MAX_SIZE are clamped to MAX_SIZE
- o_Rd_Addr  out  ADDR_W  body-RAM read address
- i_Rd_x, i_Rd_y  in  7 each  body-RAM data; data for the address driven in cycle t is valid in cycle t+1
- o_Busy  out  1  high from the cycle after start acceptance through the cycle before o_Done
- o_Done  out  1  one-cycle completion pulse
- o_Full  out  1  valid with o_Done; 1 = no free cell exists
- o_Item_x, o_Item_y  out  7 each  placed item cell; 0,0 = no item

## Operation
- LFSR:
  - 16-bit Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Shifts every cycle, unconditionally, including while busy.
  - Loads LFSR_SEED while i_Rst is high.
- Candidate mapping uses the LFSR value in the cycle i_Start is accepted:
  - x = (r ≥ XSIZE ? r − XSIZE : r) + 1, where r = lfsr[5:0].
  - y is formed the same way from lfsr[11:6] and YSIZE.
- States are IDLE, SCAN, DONE.
- IDLE:
  - i_Start=1 latches candidate, i_Head_x/y and the clamped i_Size (S).
  - Clears the try counter and goes to SCAN.
- SCAN, per candidate:
  - First scan cycle r compares the candidate against the latched head.
  - o_Rd_Addr = 0 in cycle r, 1 in cycle r+1, … , S−1 in cycle r+S−1, then holds.
  - Data for address k is compared in cycle r+k+1 against the candidate.
  - Hit means a head match or body data equal to the candidate in both x and y.
  - On a hit:
    - The candidate advances to its raster successor: x+1; if x == XSIZE then x = 1 and y+1; if y == YSIZE also then y = 1.
    - The try counter increments.
    - The scan restarts at cycle r' = hit cycle + 1 with o_Rd_Addr = 0.
    - In-flight read data from the aborted scan is discarded through a valid bit.
  - No hit through cycle r+S: next cycle is DONE.
  - If the try counter reaches XSIZE*YSIZE: next cycle is DONE with o_Full = 1.
- DONE (one cycle):
  - o_Done = 1.
  - If o_Full = 0, o_Item_x/y are updated to the candidate in this cycle.
  - If o_Full = 1, o_Item_x/y hold their previous value.
  - Returns to IDLE.
- i_Start is ignored in SCAN and DONE (no queuing).
- S = 0 means head check only.
- Reset mid-operation:
  - Returns to IDLE.
  - All outputs take their reset values; the item is cleared to 0,0.

## Timing
- Reset values:
  - o_Busy = 0, o_Done = 0, o_Full = 0.
  - o_Rd_Addr = 0.
  - o_Item_x = o_Item_y = 0.
  - LFSR = LFSR_SEED.
- Start accepted in cycle 0, so the first scan cycle is r = 1.
- Latency:
  - Done at cycle S+2 when the first candidate is free.
  - Each rejected candidate adds (hit cycle − r + 1) cycles.
- o_Done high exactly one cycle.
- o_Full and o_Item_x/y are stable from the o_Done cycle until the next accepted start.
- o_Busy = 1 in cycles 1..done−1.
- Earliest next start is accepted in the cycle after o_Done.
- Worst case: XSIZE*YSIZE candidates × (S+1) cycles. This is bounded and has no deadlock.

## Test plan
- Reset, then hold i_Rst 3 cycles -> all outputs 0; first post-reset start uses LFSR 16'hACE1 -> candidate (34,52).
- Start in the first cycle after reset. Head (24,31); S=3; body (24,32),(24,33),(24,34). -> o_Rd_Addr 0,1,2 in cycles 1..3; o_Busy cycles 1..4; o_Done at cycle 5; item (34,52); o_Full 0.
- Same stimulus but body[1] = (34,52) -> hit at cycle 3; restart cycle 4 with (35,52); o_Done at cycle 8; item (35,52).
- Same stimulus but head = (34,52) -> hit at cycle 1; restart cycle 2 with (35,52); o_Done at cycle 6.
- Body fills every cell (S=3072, each cell once) -> o_Done with o_Full=1. Item stays at its previous value. Raster wrap from (48,64) to (1,1) must occur with no hang.
- Pulse i_Start at cycle 2 during a scan -> ignored, single o_Done. Assert i_Rst at cycle 2 of a scan -> o_Busy 0 and item 0,0 the next cycle, no o_Done.

Source files
------------

// File: rtl/snake_item_placer.sv
// Item placer for the snake game: draws a pseudo-random candidate cell and scans
// the body RAM, stepping through raster successors until it finds a free cell.
//   IDLE | waiting for i_Start, LFSR free-running
//   SCAN | head check, then body RAM walk for the current candidate
//   DONE | one-cycle completion, o_Done high
module snake_item_placer #(
  parameter int          XSIZE     = 48,
  parameter int          YSIZE     = 64,
  parameter int          MAX_SIZE  = 3072,
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [6:0]        i_Head_x,
  input  logic [6:0]        i_Head_y,
  input  logic [ADDR_W-1:0] i_Size,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  input  logic [6:0]        i_Rd_x,
  input  logic [6:0]        i_Rd_y,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Full,
  output logic [6:0]        o_Item_x,
  output logic [6:0]        o_Item_y
);

  localparam int                NCELLS   = XSIZE * YSIZE;
  localparam int                TRY_W    = $clog2(NCELLS + 1);
  localparam logic [ADDR_W-1:0] SIZE_MAX = ADDR_W'(MAX_SIZE);
  localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(NCELLS - 1);
  localparam logic [6:0]        XS       = 7'(XSIZE);
  localparam logic [6:0]        YS       = 7'(YSIZE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic [6:0]        rnd_x, rnd_y, map_x, map_y;
  logic [6:0]        cand_x, cand_y, head_x, head_y, succ_x, succ_y;
  logic [ADDR_W-1:0] size_s, size_clamped, cnt, cnt_nxt;
  logic [TRY_W-1:0]  tries;
  logic              rd_vld, head_hit, body_hit, hit;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    rnd_x        = {1'b0, lfsr[5:0]};
    rnd_y        = {1'b0, lfsr[11:6]};
    map_x        = ((rnd_x >= XS) ? rnd_x - XS : rnd_x) + 7'd1;
    map_y        = ((rnd_y >= YS) ? rnd_y - YS : rnd_y) + 7'd1;
    size_clamped = (i_Size > SIZE_MAX) ? SIZE_MAX : i_Size;
    succ_x       = (cand_x == XS) ? 7'd1 : cand_x + 7'd1;
    succ_y       = cand_y;
    if (cand_x == XS) succ_y = (cand_y == YS) ? 7'd1 : cand_y + 7'd1;
    cnt_nxt      = cnt + 1'b1;
    // cnt == 0 marks the first cycle of a candidate's scan, where the head is checked
    head_hit     = (cnt == '0) && (cand_x == head_x) && (cand_y == head_y);
    body_hit     = rd_vld && (i_Rd_x == cand_x) && (i_Rd_y == cand_y);
    hit          = head_hit || body_hit;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      cand_x    <= '0;
      cand_y    <= '0;
      head_x    <= '0;
      head_y    <= '0;
      size_s    <= '0;
      cnt       <= '0;
      tries     <= '0;
      rd_vld    <= 1'b0;
      o_Rd_Addr <= '0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Full    <= 1'b0;
      o_Item_x  <= '0;
      o_Item_y  <= '0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            cand_x    <= map_x;
            cand_y    <= map_y;
            head_x    <= i_Head_x;
            head_y    <= i_Head_y;
            size_s    <= size_clamped;
            tries     <= '0;
            cnt       <= '0;
            rd_vld    <= 1'b0;
            o_Rd_Addr <= '0;
            o_Busy    <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            // restart on the raster successor; rd_vld drops so stale read data is ignored
            cand_x    <= succ_x;
            cand_y    <= succ_y;
            cnt       <= '0;
            rd_vld    <= 1'b0;
            o_Rd_Addr <= '0;
            tries     <= tries + 1'b1;
            if (tries == TRY_LAST) begin
              o_Full <= 1'b1;
              o_Done <= 1'b1;
              o_Busy <= 1'b0;
              state  <= DONE;
            end
          end else if (cnt == size_s) begin
            o_Full   <= 1'b0;
            o_Done   <= 1'b1;
            o_Busy   <= 1'b0;
            o_Item_x <= cand_x;
            o_Item_y <= cand_y;
            state    <= DONE;
          end else begin
            cnt    <= cnt_nxt;
            rd_vld <= 1'b1;
            if (cnt_nxt < size_s) o_Rd_Addr <= cnt_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
